// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the alu_core execute-stage ALU.
//   - op-class encodings (OP_DP, OP_MEM, OP_BR, OP_SHIFT)
//   - data-processing opcodes carried in cmd[3:0] (CMD_AND..CMD_MVN)
//   - bit positions of the NZCV flags within the 4-bit flag register
//   - small opcode classification helpers used by the core
package alu_pkg;

  localparam logic [1:0] OP_DP    = 2'd0;
  localparam logic [1:0] OP_MEM   = 2'd1;
  localparam logic [1:0] OP_BR    = 2'd2;
  localparam logic [1:0] OP_SHIFT = 2'd3;

  localparam logic [3:0] CMD_AND = 4'h0;
  localparam logic [3:0] CMD_EOR = 4'h1;
  localparam logic [3:0] CMD_SUB = 4'h2;
  localparam logic [3:0] CMD_RSB = 4'h3;
  localparam logic [3:0] CMD_ADD = 4'h4;
  localparam logic [3:0] CMD_ADC = 4'h5;
  localparam logic [3:0] CMD_SBC = 4'h6;
  localparam logic [3:0] CMD_RSC = 4'h7;
  localparam logic [3:0] CMD_TST = 4'h8;
  localparam logic [3:0] CMD_TEQ = 4'h9;
  localparam logic [3:0] CMD_CMP = 4'hA;
  localparam logic [3:0] CMD_CMN = 4'hB;
  localparam logic [3:0] CMD_ORR = 4'hC;
  localparam logic [3:0] CMD_MOV = 4'hD;
  localparam logic [3:0] CMD_BIC = 4'hE;
  localparam logic [3:0] CMD_MVN = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // TST/TEQ/CMP/CMN occupy 8..B and only write flags.
  function automatic logic is_compare(input logic [3:0] opc);
    return (opc[3:2] == 2'b10);
  endfunction

  // Commands whose result comes from the adder (C/V taken from it).
  function automatic logic is_arith(input logic [3:0] opc);
    logic res;
    res = 1'b0;
    case (opc)
      CMD_SUB, CMD_RSB, CMD_ADD, CMD_ADC,
      CMD_SBC, CMD_RSC, CMD_CMP, CMD_CMN: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_adder.sv
// alu_adder: combinational WIDTH-bit adder shared by the data-processing,
// memory-address and branch-target paths of alu_core.
// Ports:
//   a, b      operands
//   cin       carry in
//   invert_b  use ~b instead of b (subtract = a + ~b + 1)
//   sum       wrapped sum
//   cout      carry out of bit WIDTH-1 (no-borrow for subtraction)
//   ovf       signed overflow
module alu_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             invert_b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  always_comb begin
    b_eff = invert_b ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    sum   = full[WIDTH-1:0];
    cout  = full[WIDTH];
    // Overflow: both addends share a sign that the sum does not.
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_core.sv
// alu_core: registered ARM-style integer ALU, 1-cycle latency.
// Ports:
//   clk, rst_n     clock (rising edge), async active-low reset
//   in_valid       request strobe; A/B/op/cmd sampled when high
//   A, B           operands (Rn, Src2)
//   op             class: 0 data-proc, 1 mem address, 2 branch, 3 shift/reserved
//   cmd            cmd[3:0] opcode; cmd[5:4] ignored
//   result, flag   registered result and {N,Z,C,V}
//   out_valid      high one cycle after an accepted request
// Build option: define ALU_SHIFT_EN to turn op=3 into a shifter
// (B[4:0] amount, cmd[1:0] = LSL/LSR/ASR/ROR). Without it op=3 yields 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic [5:0]       cmd,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flag,
  output logic             out_valid
);

  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flag_q, flag_d;
  logic             out_valid_q, out_valid_d;

  logic [3:0]       opc;
  logic             c_in;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_inv, add_cout, add_ovf;
  logic [WIDTH-1:0] logic_res, dp_res;

  logic unused_cmd_hi;
  assign unused_cmd_hi = ^cmd[5:4];

  assign opc  = cmd[3:0];
  assign c_in = flag_q[FLAG_C];

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a        (add_a),
    .b        (add_b),
    .cin      (add_cin),
    .invert_b (add_inv),
    .sum      (add_sum),
    .cout     (add_cout),
    .ovf      (add_ovf)
  );

  // Adder operand steering; reverse-subtracts swap A and B.
  always_comb begin
    add_a   = A;
    add_b   = B;
    add_cin = 1'b0;
    add_inv = 1'b0;
    case (op)
      OP_DP: begin
        case (opc)
          CMD_SUB, CMD_CMP: begin
            add_inv = 1'b1;
            add_cin = 1'b1;
          end
          CMD_RSB: begin
            add_a   = B;
            add_b   = A;
            add_inv = 1'b1;
            add_cin = 1'b1;
          end
          CMD_ADC: add_cin = c_in;
          CMD_SBC: begin
            add_inv = 1'b1;
            add_cin = c_in;
          end
          CMD_RSC: begin
            add_a   = B;
            add_b   = A;
            add_inv = 1'b1;
            add_cin = c_in;
          end
          default: ;
        endcase
      end
      OP_MEM: begin
        // cmd[3] is the U (up) bit: clear means subtract the offset.
        if (!cmd[3]) begin
          add_inv = 1'b1;
          add_cin = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    logic_res = '0;
    case (opc)
      CMD_AND, CMD_TST: logic_res = A & B;
      CMD_EOR, CMD_TEQ: logic_res = A ^ B;
      CMD_ORR:          logic_res = A | B;
      CMD_MOV:          logic_res = B;
      CMD_BIC:          logic_res = A & ~B;
      CMD_MVN:          logic_res = ~B;
      default:          logic_res = '0;
    endcase
    dp_res = is_arith(opc) ? add_sum : logic_res;
  end

`ifdef ALU_SHIFT_EN
  logic [4:0]              sh_amt;
  logic [WIDTH:0]          lsl_w;
  logic [WIDTH:0]          lsr_w;
  logic signed [WIDTH:0]   asr_w;
  logic [WIDTH-1:0]        ror_w;
  logic [WIDTH-1:0]        sh_res;
  logic                    sh_c;

  // One extra bit beyond the word catches the last bit shifted out.
  always_comb begin
    sh_amt = B[4:0];
    lsl_w  = {1'b0, A} << sh_amt;
    lsr_w  = {A, 1'b0} >> sh_amt;
    asr_w  = $signed({A, 1'b0}) >>> sh_amt;
    ror_w  = (A >> sh_amt) | (A << (WIDTH - int'(sh_amt)));
    sh_res = A;
    sh_c   = c_in;
    if (sh_amt != 5'd0) begin
      case (cmd[1:0])
        2'd0: begin
          sh_res = lsl_w[WIDTH-1:0];
          sh_c   = lsl_w[WIDTH];
        end
        2'd1: begin
          sh_res = lsr_w[WIDTH:1];
          sh_c   = lsr_w[0];
        end
        2'd2: begin
          sh_res = asr_w[WIDTH:1];
          sh_c   = asr_w[0];
        end
        default: begin
          sh_res = ror_w;
          sh_c   = ror_w[WIDTH-1];
        end
      endcase
    end
  end
`endif

  always_comb begin
    result_d    = result_q;
    flag_d      = flag_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      case (op)
        OP_DP: begin
          if (!is_compare(opc)) result_d = dp_res;
          flag_d[FLAG_N] = dp_res[WIDTH-1];
          flag_d[FLAG_Z] = (dp_res == '0);
          if (is_arith(opc)) begin
            flag_d[FLAG_C] = add_cout;
            flag_d[FLAG_V] = add_ovf;
          end else begin
            flag_d[FLAG_C] = 1'b0;
          end
        end
        OP_MEM, OP_BR: result_d = add_sum;
        default: begin
`ifdef ALU_SHIFT_EN
          result_d       = sh_res;
          flag_d[FLAG_N] = sh_res[WIDTH-1];
          flag_d[FLAG_Z] = (sh_res == '0);
          flag_d[FLAG_C] = sh_c;
`else
          result_d = '0;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      flag_q      <= 4'b0000;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      flag_q      <= flag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign flag      = flag_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors with hand-computed results, checked by a
// scoreboard queue that a negedge monitor drains whenever out_valid is high.
// Define ALU_SHIFT_EN for both DUT and bench to exercise the shifter.
module tb_alu_core;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [1:0]   op = '0;
  logic [5:0]   cmd = '0;
  logic [W-1:0] result;
  logic [3:0]   flag;
  logic         out_valid;

  alu_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .op        (op),
    .cmd       (cmd),
    .result    (result),
    .flag      (flag),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
    int           issue;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_tests = 0;
  int n_fail = 0;
  int n_pushed = 0;
  int n_seen = 0;
  logic [W-1:0] last_r = '0;
  logic [3:0]   last_f = '0;

  // Monitor: pops one expectation per out_valid; checks hold otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_r = '0;
      last_f = '0;
    end else if (out_valid) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: result=%h flag=%b with nothing outstanding", result, flag);
      end else begin
        e = sb.pop_front();
        n_seen++;
        if (result !== e.r || flag !== e.f || cyc != e.issue + 1) begin
          n_fail++;
          $display("FAIL %s: got result=%h flag=%b cycle=%0d, expected result=%h flag=%b cycle=%0d",
                   e.name, result, flag, cyc, e.r, e.f, e.issue + 1);
        end
        last_r = e.r;
        last_f = e.f;
      end
    end else begin
      n_tests++;
      if (result !== last_r || flag !== last_f) begin
        n_fail++;
        $display("FAIL hold: got result=%h flag=%b, expected result=%h flag=%b",
                 result, flag, last_r, last_f);
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic issue(input string name, input logic [1:0] o, input logic [3:0] c,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [3:0] ef);
    logic [1:0] hi;
    hi = 2'($urandom_range(0, 3));
    op = o;
    cmd = {hi, c};
    A = a;
    B = b;
    in_valid = 1'b1;
    sb.push_back('{er, ef, cyc, name});
    n_pushed++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    cmd = 6'($urandom_range(0, 63));
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, then release between edges.
    #8;
    check("reset_result", result, '0);
    check("reset_flag", W'(flag), '0);
    check("reset_valid", W'(out_valid), '0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Request in flight, then async reset without a clock edge.
    op = 2'd0; cmd = 6'h04; A = 32'h7FFF_FFFF; B = 32'h1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset_valid", W'(out_valid), W'(1));
    check("pre_reset_result", result, 32'h8000_0000);
    rst_n = 1'b0;
    #1;
    check("midreset_result", result, '0);
    check("midreset_flag", W'(flag), '0);
    check("midreset_valid", W'(out_valid), '0);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four back-to-back requests (throughput), then a gap.
    issue("and",  2'd0, 4'h0, 32'd14, 32'd45, 32'd12, 4'b0000);
    issue("eor",  2'd0, 4'h1, 32'd87, 32'd51, 32'd100, 4'b0000);
    issue("sub",  2'd0, 4'h2, 32'd26, 32'd35, 32'hFFFF_FFF7, 4'b1000);
    issue("add",  2'd0, 4'h4, 32'd67, 32'd35, 32'd102, 4'b0000);
    idle(2);

    issue("add_ovf",   2'd0, 4'h4, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001);
    issue("add_carry", 2'd0, 4'h4, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110);
    issue("adc",       2'd0, 4'h5, 32'h0, 32'h0, 32'h1, 4'b0000);
    issue("cmp_eq",    2'd0, 4'hA, 32'd5, 32'd5, 32'h1, 4'b0110);
    issue("mem_down",  2'd1, 4'h0, 32'd100, 32'd4, 32'd96, 4'b0110);
    issue("mem_up",    2'd1, 4'h8, 32'd100, 32'd4, 32'd104, 4'b0110);
    issue("branch",    2'd2, 4'h3, 32'h1000, 32'h20, 32'h1020, 4'b0110);
    idle(1);

    issue("sbc_c1",    2'd0, 4'h6, 32'd10, 32'd3, 32'd7, 4'b0010);
    issue("sbc_borrow",2'd0, 4'h6, 32'd3, 32'd10, 32'hFFFF_FFF9, 4'b1000);
    issue("sbc_c0",    2'd0, 4'h6, 32'd10, 32'd3, 32'd6, 4'b0010);
    issue("rsb",       2'd0, 4'h3, 32'd3, 32'd10, 32'd7, 4'b0010);
    issue("rsc_c1",    2'd0, 4'h7, 32'd10, 32'd3, 32'hFFFF_FFF9, 4'b1000);
    issue("rsc_c0",    2'd0, 4'h7, 32'd1, 32'd5, 32'd3, 4'b0010);
    issue("cmn",       2'd0, 4'hB, 32'h8000_0000, 32'h8000_0000, 32'd3, 4'b0111);
    issue("tst",       2'd0, 4'h8, 32'hF0, 32'h0F, 32'd3, 4'b0101);
    issue("teq",       2'd0, 4'h9, 32'h8000_0000, 32'h0, 32'd3, 4'b1001);
    issue("orr",       2'd0, 4'hC, 32'hF0, 32'h0F, 32'hFF, 4'b0001);
    issue("mov",       2'd0, 4'hD, 32'h1234, 32'h0, 32'h0, 4'b0101);
    issue("bic",       2'd0, 4'hE, 32'hFF, 32'h0F, 32'hF0, 4'b0001);
    issue("mvn",       2'd0, 4'hF, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'b1001);
    issue("add_clrv",  2'd0, 4'h4, 32'd1, 32'd1, 32'd2, 4'b0000);
    idle(1);

`ifdef ALU_SHIFT_EN
    issue("asr",       2'd3, 4'h2, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b1000);
    issue("lsl",       2'd3, 4'h0, 32'h8000_0001, 32'd1, 32'h2, 4'b0010);
    issue("lsr",       2'd3, 4'h1, 32'd3, 32'd1, 32'd1, 4'b0010);
    issue("ror",       2'd3, 4'h3, 32'd1, 32'd1, 32'h8000_0000, 4'b1010);
    issue("lsr_amt0",  2'd3, 4'h1, 32'd0, 32'd0, 32'd0, 4'b0110);
`else
    issue("op3_off",   2'd3, 4'h2, 32'h8000_0000, 32'd4, 32'h0, 4'b0000);
    issue("op3_hold",  2'd3, 4'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 4'b0000);
`endif
    idle(3);

    check("all_outputs_seen", W'(n_seen), W'(n_pushed));
    check("queue_empty", W'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered 32-bit ARM-style integer ALU for the datapath execute stage.
- Takes two operands, a 2-bit operation class `op` and a 6-bit command `cmd`.
- Produces a 32-bit result and a 4-bit NZCV flag register one clock after a valid request.
- Stored C flag feeds the carry-using commands (ADC/SBC/RSC).

Parameters:
- WIDTH, 32, operand/result width (flag semantics defined at bit WIDTH-1).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request strobe; operands sampled when high
- A  input  WIDTH  operand A (Rn)
- B  input  WIDTH  operand B (Src2)
- op  input  2  class: 0 data-processing, 1 memory address, 2 branch target, 3 shift (optional) / reserved
- cmd  input  6  command; cmd[3:0] opcode, cmd[5:4] ignored
- result  output  WIDTH  registered result
- flag  output  4  registered flags {N,Z,C,V} = flag[3:0]
- out_valid  output  1  high one cycle after an accepted request

Behaviour:
- Reset (async assert, sync deassert on clk): result=0, flag=4'b0000, out_valid=0.
- Latency is 1 cycle. A request with in_valid=1 at edge k gives updated result/flag and out_valid=1 after edge k.
- in_valid=0: result and flag hold, out_valid=0. A new request may be issued every cycle.
- op=0, cmd[3:0] opcodes:
  - 0 AND; 1 EOR; 2 SUB A-B; 3 RSB B-A; 4 ADD A+B.
  - 5 ADC A+B+C; 6 SBC A-B-!C; 7 RSC B-A-!C.
  - 8 TST (AND); 9 TEQ (EOR); A CMP (SUB); B CMN (ADD).
  - C ORR; D MOV (B); E BIC A&~B; F MVN ~B.
- TST/TEQ/CMP/CMN update flags only; result holds.
- Flags on every op=0 command:
  - N = res[WIDTH-1]; Z = (res==0).
  - Arithmetic: C = carry-out of the adder. For subtract, C = no-borrow (1 when minuend >= subtrahend, unsigned). V = signed overflow.
  - Logical/move: C=0, V unchanged.
- Subtract is implemented as A + ~B + 1 (with carry-in C for SBC/RSC). All arithmetic wraps modulo 2^WIDTH.
- op=1: result = cmd[3] ? A+B : A-B (bit 3 is the U/up bit); flags unchanged.
- op=2: result = A+B; flags unchanged.
- op=3 without the optional feature: result=0, flags unchanged.
- Reset mid-operation discards the in-flight request; out_valid=0 immediately.

Optional Feature:
- Macro ALU_SHIFT_EN.
- Defined: op=3 is a shift unit. Shift amount is B[4:0]; cmd[1:0] selects 0 LSL, 1 LSR, 2 ASR, 3 ROR.
  - Amount 0 returns A with C unchanged. Otherwise C = last bit shifted out.
  - N and Z updated from the result; V unchanged.
- Undefined: op=3 returns result=0 with flags unchanged; no shifter logic is synthesised.

Decomposition:
- Package alu_pkg: op-class constants (OP_DP, OP_MEM, OP_BR, OP_SHIFT), 4-bit opcode constants (CMD_AND..CMD_MVN), flag index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- Sub-module alu_adder: combinational WIDTH-bit adder.
  - Inputs: a, b, cin, invert_b.
  - Outputs: sum, cout, ovf.
  - Shared by all arithmetic, memory and branch paths.

Test Plan:
- Reset: assert rst_n=0 mid-request -> result=0, flag=0000, out_valid=0 without a clock edge.
- op=0, cmd=0 (AND), A=14, B=45 -> result=12, flag=0000. Then op=0, cmd=1 (EOR), A=87, B=51 -> result=100, flag=0000.
- op=0, cmd=2 (SUB), A=26, B=35 -> result=0xFFFFFFF7, flag=1000. Then cmd=4 (ADD), A=67, B=35 -> result=102, flag=0000.
- ADD 0x7FFFFFFF+1 -> 0x80000000, flag=1001. ADD 0xFFFFFFFF+1 -> 0, flag=0110. Then ADC 0+0 -> 1 (uses stored C=1).
- CMP A=5, B=5 -> result holds previous value, flag=0110. op=1, cmd=0, A=100, B=4 -> result=96, flags unchanged.
- Throughput: in_valid held high for 4 back-to-back requests -> out_valid high 4 cycles, each result appearing 1 cycle after its request. With ALU_SHIFT_EN: op=3, cmd=2, A=0x80000000, B=4 -> 0xF8000000, flag C=0, N=1.
